// File: rtl/dual_fetch_ctrl.sv
// Fetch sequencer for the dual-issue core: owns the fetch PC, captures two-word
// memory reads into a small FIFO and presents the two oldest entries to decode.
module dual_fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IM_WORDS = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_en,
    output logic [31:0]                  im_addr,
    input  logic [31:0]                  im_data,
    input  logic [31:0]                  im_data1,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    input  logic [1:0]                   issue_cnt,
    output logic                         inst0_valid,
    output logic [31:0]                  inst0,
    output logic [31:0]                  pc0,
    output logic                         inst1_valid,
    output logic [31:0]                  inst1,
    output logic [31:0]                  pc1,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(IM_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(IM_WORDS - 1);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd1, wr1;
    logic [CW-1:0] count_q, count_d, issue_eff, pops, avail, pushes;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          boundary, push1, push2, wr_en0, wr_en1;

    always_comb begin
        rd1       = rd_q + 1'b1;
        wr1       = wr_q + 1'b1;
        // The last memory word has no valid successor, so only one word is taken there.
        boundary  = (fetch_pc_q[IW+1:2] == LAST_IDX);
        issue_eff = (issue_cnt == 2'd0) ? CW'(0) : (issue_cnt == 2'd1) ? CW'(1) : CW'(2);
        pops      = (issue_eff > count_q) ? count_q : issue_eff;
        avail     = count_q - pops;
        push1     = fetch_en && boundary && (avail <= DEPTH_M1);
        push2     = fetch_en && !boundary && (avail <= DEPTH_M2);
        pushes    = push2 ? CW'(2) : (push1 ? CW'(1) : CW'(0));
        wr_en0    = !reset && !redirect_valid && (push1 || push2);
        wr_en1    = !reset && !redirect_valid && push2;

        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            rd_d       = '0;
            wr_d       = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            rd_d       = rd_q + PW'(pops);
            wr_d       = wr_q + PW'(pushes);
            count_d    = avail + pushes;
            fetch_pc_d = fetch_pc_q + (push2 ? 32'd8 : (push1 ? 32'd4 : 32'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (wr_en0) begin
            inst_mem_q[wr_q] <= im_data;
            pc_mem_q[wr_q]   <= fetch_pc_q;
        end
        if (wr_en1) begin
            inst_mem_q[wr1] <= im_data1;
            pc_mem_q[wr1]   <= fetch_pc_q + 32'd4;
        end
    end

    // Decode handshake: slot N carries an instruction when instN_valid=1, and
    // issue_cnt reports how many valid slots (oldest first) were taken this cycle.
    assign im_addr     = fetch_pc_q;
    assign inst0_valid = (count_q != '0);
    assign inst1_valid = (count_q >= CW'(2));
    assign inst0       = inst_mem_q[rd_q];
    assign pc0         = pc_mem_q[rd_q];
    assign inst1       = inst_mem_q[rd1];
    assign pc1         = pc_mem_q[rd1];
    assign q_count     = count_q;

endmodule

// File: tb/tb_dual_fetch_ctrl.sv
// Self-checking bench for dual_fetch_ctrl: directed vector table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_dual_fetch_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          fetch_en;
    logic [31:0]   im_addr;
    logic [31:0]   im_data;
    logic [31:0]   im_data1;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [1:0]    issue_cnt;
    logic          inst0_valid, inst1_valid;
    logic [31:0]   inst0, pc0, inst1, pc1;
    logic [CW-1:0] q_count;

    logic [31:0] mem [128];
    logic [6:0]  idx0, idx1;

    assign idx0     = im_addr[8:2];
    assign idx1     = idx0 + 7'd1;
    assign im_data  = mem[idx0];
    assign im_data1 = mem[idx1];

    dual_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0), .IM_WORDS(128)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .im_addr(im_addr),
        .im_data(im_data), .im_data1(im_data1), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .issue_cnt(issue_cnt),
        .inst0_valid(inst0_valid), .inst0(inst0), .pc0(pc0),
        .inst1_valid(inst1_valid), .inst1(inst1), .pc1(pc1), .q_count(q_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: {pc, inst} entries, oldest first
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances by one clock edge from the spec's rules.
    task automatic model_edge(input logic rst, input logic fe, input logic rv,
                              input logic [31:0] rpc, input logic [1:0] ic);
        int n;
        int idx;
        int free;
        if (rst) begin
            exp_q.delete();
            m_pc = 32'h0;
        end else if (rv) begin
            exp_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            n = (ic == 2'd3) ? 2 : int'(ic);
            for (int k = 0; k < n; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
            free = DEPTH - exp_q.size();
            idx  = int'(m_pc[8:2]);
            if (fe && idx == 127 && free >= 1) begin
                exp_q.push_back({m_pc, mem[idx]});
                m_pc = m_pc + 32'd4;
            end else if (fe && idx != 127 && free >= 2) begin
                exp_q.push_back({m_pc, mem[idx]});
                exp_q.push_back({m_pc + 32'd4, mem[(idx + 1) % 128]});
                m_pc = m_pc + 32'd8;
            end
        end
    endtask

    // driver: apply inputs for one cycle, step the model, land on the next negedge
    task automatic step(input logic rst, input logic fe, input logic rv,
                        input logic [31:0] rpc, input logic [1:0] ic);
        reset          = rst;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        issue_cnt      = ic;
        model_edge(rst, fe, rv, rpc, ic);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".im_addr"}, im_addr, m_pc);
        chk({tag, ".q_count"}, 32'(q_count), exp_q.size());
        chk({tag, ".v0"}, 32'(inst0_valid), 32'(exp_q.size() >= 1));
        chk({tag, ".v1"}, 32'(inst1_valid), 32'(exp_q.size() >= 2));
        if (exp_q.size() >= 1) begin
            chk({tag, ".pc0"}, pc0, exp_q[0][63:32]);
            chk({tag, ".inst0"}, inst0, exp_q[0][31:0]);
        end
        if (exp_q.size() >= 2) begin
            chk({tag, ".pc1"}, pc1, exp_q[1][63:32]);
            chk({tag, ".inst1"}, inst1, exp_q[1][31:0]);
        end
    endtask

    typedef struct {
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic [1:0]  ic;
        int          cnt;
        logic [31:0] addr;
        logic        v0;
        logic [31:0] pc0;
        logic        v1;
        logic [31:0] pc1;
    } vec_t;

    function automatic vec_t mk(input logic fe, input logic rv, input logic [31:0] rpc,
                                input logic [1:0] ic, input int cnt, input logic [31:0] addr,
                                input logic v0, input logic [31:0] p0,
                                input logic v1, input logic [31:0] p1);
        vec_t v;
        v.fe = fe; v.rv = rv; v.rpc = rpc; v.ic = ic; v.cnt = cnt; v.addr = addr;
        v.v0 = v0; v.pc0 = p0; v.v1 = v1; v.pc1 = p1;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        logic [31:0] ei;
        logic [31:0] rpc;
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; issue_cnt = '0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h100 + i;

        //            fe    rv    rpc         ic    cnt addr        v0    pc0         v1    pc1
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,     2'd0, 2, 32'h8,     1'b1, 32'h0,     1'b1, 32'h4);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0,     2'd0, 4, 32'h10,    1'b1, 32'h0,     1'b1, 32'h4);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0,     2'd0, 4, 32'h10,    1'b1, 32'h0,     1'b1, 32'h4);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,     2'd1, 3, 32'h10,    1'b1, 32'h4,     1'b1, 32'h8);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,     2'd1, 4, 32'h18,    1'b1, 32'h8,     1'b1, 32'hC);
        vecs[5]  = mk(1'b1, 1'b1, 32'h43,    2'd2, 0, 32'h40,    1'b0, 32'h0,     1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,     2'd0, 2, 32'h48,    1'b1, 32'h40,    1'b1, 32'h44);
        vecs[7]  = mk(1'b1, 1'b1, 32'h1FC,   2'd0, 0, 32'h1FC,   1'b0, 32'h0,     1'b0, 32'h0);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0,     2'd0, 1, 32'h200,   1'b1, 32'h1FC,   1'b0, 32'h0);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0,     2'd0, 3, 32'h208,   1'b1, 32'h1FC,   1'b1, 32'h200);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,     2'd2, 1, 32'h208,   1'b1, 32'h204,   1'b0, 32'h0);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,     2'd2, 0, 32'h208,   1'b0, 32'h0,     1'b0, 32'h0);
        vecs[12] = mk(1'b0, 1'b0, 32'h0,     2'd3, 0, 32'h208,   1'b0, 32'h0,     1'b0, 32'h0);
        vecs[13] = mk(1'b1, 1'b0, 32'h0,     2'd3, 2, 32'h210,   1'b1, 32'h208,   1'b1, 32'h20C);
        vecs[14] = mk(1'b1, 1'b0, 32'h0,     2'd3, 2, 32'h218,   1'b1, 32'h210,   1'b1, 32'h214);

        step(1'b1, 1'b1, 1'b0, 32'h0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 2'd0);
        chk("reset.q_count", 32'(q_count), 32'd0);
        chk("reset.im_addr", im_addr, 32'h0);
        chk("reset.v0", 32'(inst0_valid), 32'd0);
        chk("reset.v1", 32'(inst1_valid), 32'd0);

        for (int i = 0; i < 15; i++) begin
            step(1'b0, vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].ic);
            chk($sformatf("vec%0d.q_count", i), 32'(q_count), vecs[i].cnt);
            chk($sformatf("vec%0d.im_addr", i), im_addr, vecs[i].addr);
            chk($sformatf("vec%0d.v0", i), 32'(inst0_valid), 32'(vecs[i].v0));
            chk($sformatf("vec%0d.v1", i), 32'(inst1_valid), 32'(vecs[i].v1));
            if (vecs[i].v0) begin
                ei = 32'h100 + 32'(vecs[i].pc0[8:2]);
                chk($sformatf("vec%0d.pc0", i), pc0, vecs[i].pc0);
                chk($sformatf("vec%0d.inst0", i), inst0, ei);
            end
            if (vecs[i].v1) begin
                ei = 32'h100 + 32'(vecs[i].pc1[8:2]);
                chk($sformatf("vec%0d.pc1", i), pc1, vecs[i].pc1);
                chk($sformatf("vec%0d.inst1", i), inst1, ei);
            end
        end

        // steady dual issue from reset: pairs (0,4),(8,12),...
        step(1'b1, 1'b1, 1'b0, 32'h0, 2'd0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 2'd2);
            chk($sformatf("dual%0d.q_count", k), 32'(q_count), 32'd2);
            chk($sformatf("dual%0d.pc0", k), pc0, 32'(8 * k));
            chk($sformatf("dual%0d.pc1", k), pc1, 32'(8 * k + 4));
        end

        // back-to-back redirects: last wins, nothing pushed while held
        step(1'b0, 1'b1, 1'b1, 32'h100, 2'd0);
        step(1'b0, 1'b1, 1'b1, 32'h82, 2'd0);
        chk("b2b.im_addr", im_addr, 32'h80);
        chk("b2b.q_count", 32'(q_count), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 2'd0);
        chk("b2b.pc0", pc0, 32'h80);
        // reset overrides redirect and pops
        step(1'b1, 1'b1, 1'b1, 32'h300, 2'd2);
        chk("rst_over.im_addr", im_addr, 32'h0);
        chk("rst_over.q_count", 32'(q_count), 32'd0);

        // randomized traffic against the reference model
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 2))
                0:       rpc = $urandom_range(0, 1023);
                1:       rpc = 32'h1F0 + $urandom_range(0, 15);
                default: rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 19) == 0),
                 rpc,
                 2'($urandom_range(0, 3)));
            check_model($sformatf("rand%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
